// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative radix-2 RV32M multiply/divide unit with valid/ready handshake
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic                 a_neg, b_neg, div_zero, div_ovf, is_div;
    logic [WIDTH-1:0]     a_mag, b_mag, step_m, quo, rem, res_calc;
    logic [2*WIDTH-1:0]   step_p, step_out, prod_fix;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;

    always_comb begin
        a_neg    = in_a[WIDTH-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        b_neg    = in_b[WIDTH-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        div_zero = op[2] && (in_b == '0);
        div_ovf  = op[2] && !op[0] && (in_a == MIN_NEG) && (in_b == ALL_ONES);
    end

    // One shared iteration datapath: fed from the magnitudes on the accepting
    // edge (which performs iteration 0) and from the registers during CALC.
    always_comb begin
        is_div = (state_q == IDLE) ? op[2] : op_q[2];
        if (state_q == IDLE) begin
            step_p = op[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            step_m = op[2] ? b_mag : a_mag;
        end else begin
            step_p = p_q;
            step_m = m_q;
        end
        mul_sum   = {1'b0, step_p[2*WIDTH-1:WIDTH]} + (step_p[0] ? {1'b0, step_m} : '0);
        div_shift = {step_p[2*WIDTH-1:WIDTH], step_p[WIDTH-1]};
        div_trial = div_shift - {1'b0, step_m};
        if (!is_div)
            step_out = {mul_sum, step_p[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            step_out = {div_shift[WIDTH-1:0], step_p[WIDTH-2:0], 1'b0};
        else
            step_out = {div_trial[WIDTH-1:0], step_p[WIDTH-2:0], 1'b1};
    end

    // The full product is negated so MULH/MULHSU borrow correctly into the upper half.
    always_comb begin
        prod_fix = neg_q ? -step_out : step_out;
        quo      = step_out[WIDTH-1:0];
        rem      = step_out[2*WIDTH-1:WIDTH];
        res_calc = '0;
        case (op_q)
            3'b000:                 res_calc = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res_calc = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         res_calc = neg_q ? -quo : quo;
            default:                res_calc = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        m_d      = m_q;
        p_d      = p_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (div_zero) begin
                        result_d = op[1] ? in_a : ALL_ONES;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : in_a;
                        state_d  = DONE;
                    end else begin
                        p_d     = step_out;
                        m_d     = step_m;
                        neg_d   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
                        cnt_d   = CNT_W'(1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                p_d   = step_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    result_d = res_calc;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            m_q      <= m_d;
            p_q      <= p_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq at WIDTH=32 and WIDTH=8
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        iv32, iv8, out_ready;
    logic        ir32, ov32, busy32, ir8, ov8, busy8;
    logic [31:0] res32;
    logic [7:0]  res8;
    bit          sel8;
    logic        m_ov, m_ir, m_busy;
    logic [31:0] m_res;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op_i),
        .in_a(a_i), .in_b(b_i), .out_valid(ov32), .out_ready(out_ready),
        .result(res32), .busy(busy32)
    );

    alu_muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op_i),
        .in_a(a_i[7:0]), .in_b(b_i[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .result(res8), .busy(busy8)
    );

    assign m_ov   = sel8 ? ov8 : ov32;
    assign m_ir   = sel8 ? ir8 : ir32;
    assign m_busy = sel8 ? busy8 : busy32;
    assign m_res  = sel8 ? {24'b0, res8} : res32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on w-bit operands.
    function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, up, rr;
        longint      sa, sb, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        case (o)
            3'd0: r = longint'(ua * ub);
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * longint'(ub)) >>> w;
            3'd3: begin up = ua * ub; r = longint'(up >> w); end
            3'd4: r = (ub == 0) ? -1 : sa / sb;
            3'd5: r = (ub == 0) ? -1 : longint'(ua / ub);
            3'd6: r = (ub == 0) ? sa : sa % sb;
            default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
        endcase
        rr = r;
        rr = rr & mask;
        return rr[31:0];
    endfunction

    task automatic run_op(input bit is8, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit ready_bad);
        sel8 = is8;
        op_i = o;
        a_i  = a;
        b_i  = b;
        iv32 = !is8;
        iv8  = is8;
        @(negedge clk);
        iv32 = 1'b0;
        iv8  = 1'b0;
        a_i  = $urandom;
        b_i  = $urandom;
        op_i = 3'($urandom);
        lat = 1;
        ready_bad = 1'b0;
        while (!m_ov && lat < 100) begin
            if (m_ir || !m_busy) ready_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (m_ir || !m_busy) ready_bad = 1'b1;
        res = m_res;
        if (out_ready) @(negedge clk);
    endtask

    vec_t        tbl[14];
    logic [31:0] res, a, b, mask, mn;
    logic [2:0]  o;
    int          lat, w, r;
    bit          rb;

    initial begin
        tbl[0]  = '{3'd0, 32'd7,        32'd6,        32'h0000002A, 32};
        tbl[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32};
        tbl[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32};
        tbl[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
        tbl[4]  = '{3'd5, 32'd100,      32'd7,        32'h0000000E, 32};
        tbl[5]  = '{3'd7, 32'd100,      32'd7,        32'h00000002, 32};
        tbl[6]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
        tbl[7]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
        tbl[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'h00000005, 1};
        tbl[10] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        tbl[11] = '{3'd7, 32'd5,        32'd0,        32'h00000005, 1};
        tbl[12] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[13] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

        rst_n = 1'b0; iv32 = 1'b0; iv8 = 1'b0; out_ready = 1'b1;
        op_i = '0; a_i = '0; b_i = '0; sel8 = 1'b0;
        #1;
        check("rst_in_ready",  32'(ir32),   32'd1);
        check("rst_out_valid", 32'(ov32),   32'd0);
        check("rst_busy",      32'(busy32), 32'd0);
        check("rst_result",    res32,       32'd0);
        check("rst8_in_ready", 32'(ir8),    32'd1);
        check("rst8_result",   32'(res8),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, rb);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_busy_window", i), 32'(rb), 32'd0);
            check($sformatf("vec%0d_ready_after", i), 32'(ir32), 32'd1);
        end

        out_ready = 1'b0;
        run_op(1'b0, 3'd5, 32'd1000, 32'd3, res, lat, rb);
        check("bp_first_result", res, 32'd333);
        for (int k = 0; k < 10; k++) begin
            iv32 = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9;
            @(negedge clk);
            check($sformatf("bp_hold_result_%0d", k), res32, 32'd333);
            check($sformatf("bp_hold_ready_%0d", k), 32'(ir32), 32'd0);
            check($sformatf("bp_hold_valid_%0d", k), 32'(ov32), 32'd1);
        end
        iv32 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(ov32), 32'd0);
        check("bp_release_ready", 32'(ir32), 32'd1);
        repeat (2) @(negedge clk);
        check("bp_no_second_op", 32'(busy32), 32'd0);

        sel8 = 1'b0;
        op_i = 3'd5; a_i = 32'hFFFFFFFF; b_i = 32'd3; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        check("rstmid_busy_before", 32'(busy32), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(ov32),   32'd0);
        check("rstmid_in_ready",  32'(ir32),   32'd1);
        check("rstmid_busy",      32'(busy32), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 3'd0, 32'd3, 32'd5, res, lat, rb);
        check("rstmid_mul_result", res, 32'd15);
        check("rstmid_mul_latency", 32'(lat), 32'd32);

        run_op(1'b1, 3'd0, 32'h10, 32'h10, res, lat, rb);
        check("w8_mul_result", res, 32'h00);
        check("w8_mul_latency", 32'(lat), 32'd8);
        run_op(1'b1, 3'd3, 32'h10, 32'h10, res, lat, rb);
        check("w8_mulhu_result", res, 32'h01);
        check("w8_mulhu_latency", 32'(lat), 32'd8);

        for (int i = 0; i < 200; i++) begin
            w    = (i < 140) ? 32 : 8;
            mask = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
            mn   = (w == 32) ? 32'h80000000 : 32'h00000080;
            o = 3'($urandom);
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 7);
            case (r)
                0: b = 32'd0;
                1: begin a = mn; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            a = a & mask;
            b = b & mask;
            run_op(w == 8, o, a, b, res, lat, rb);
            check($sformatf("rnd%0d_w%0d_op%0d_result", i, w, o), res, model(w, o, a, b));
            check($sformatf("rnd%0d_w%0d_op%0d_latency", i, w, o), 32'(lat),
                  (o[2] && (b == 0 || (!o[0] && a == mn && b == mask))) ? 32'd1 : 32'(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
